// File: rtl/gwas_bit_pkg.sv
// Shared widths and state encoding for the bit-index streaming block.
package gwas_bit_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int IDX_WIDTH_DEF  = 6;
  localparam int CNT_WIDTH_DEF  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage : gwas_bit_pkg

// File: rtl/gwas_bit_count.sv
// Combinational population count of a DATA_WIDTH word.
module gwas_bit_count
  import gwas_bit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count = count + CNT_WIDTH'(data[i]);
    end
  end

endmodule : gwas_bit_count

// File: rtl/lsb_find.sv
// Lowest-set-bit finder: index of the least significant one plus its one-hot isolate.
module lsb_find
  import gwas_bit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] mask,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] isolate
);

  // Two's-complement trick keeps only the lowest one; zero mask gives zero isolate.
  assign isolate = mask & (~mask + DATA_WIDTH'(1));

  always_comb begin
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule : lsb_find

// File: rtl/bit_index_stream.sv
// Streams the indices of the set bits of each accepted bitmask word, lowest first,
// one valid/ready beat per set bit (a single flagged beat for an all-zero word).
module bit_index_stream
  import gwas_bit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [CNT_WIDTH-1:0]  out_seq,
  output logic [CNT_WIDTH-1:0]  out_total,
  output logic                  out_last,
  output logic                  out_zero
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  seq_q, seq_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic                  zero_q, zero_d;

  logic [DATA_WIDTH-1:0] isolate;
  logic [IDX_WIDTH-1:0]  lsb_idx;
  logic [CNT_WIDTH-1:0]  load_count;
  logic                  emit;
  logic                  one_left;
  logic                  last_beat;

  lsb_find #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_lsb_find (
    .mask    (mask_q),
    .idx     (lsb_idx),
    .isolate (isolate)
  );

  gwas_bit_count #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_bit_count (
    .data  (data_in),
    .count (load_count)
  );

  assign emit      = (state_q == EMIT);
  // Exactly one bit left means the isolate equals the whole remaining mask.
  assign one_left  = (mask_q != '0) && (mask_q == isolate);
  assign last_beat = zero_q || one_left;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = emit;
  assign out_idx   = lsb_idx;
  assign out_seq   = seq_q;
  assign out_total = total_q;
  assign out_last  = emit && last_beat;
  assign out_zero  = emit && zero_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    total_d = total_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d  = data_in;
          total_d = load_count;
          zero_d  = (data_in == '0);
          seq_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          mask_d = mask_q & ~isolate;
          if (last_beat) begin
            seq_d   = '0;
            zero_d  = 1'b0;
            state_d = IDLE;
          end else begin
            seq_d = seq_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      seq_q   <= '0;
      total_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      total_q <= total_d;
      zero_q  <= zero_d;
    end
  end

endmodule : bit_index_stream

// File: tb/tb_bit_index_stream.sv
// Directed bench for bit_index_stream with hand-computed beat sequences.
module tb_bit_index_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic [6:0]  out_seq;
  logic [6:0]  out_total;
  logic        out_last;
  logic        out_zero;

  int n_checks;
  int n_errors;

  bit_index_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_seq   (out_seq),
    .out_total (out_total),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d);
    int waited;
    waited = 0;
    while (!in_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      data_in  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic beat(input string tag, input int idx, input int seq, input int total,
                      input logic last, input logic zero);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_idx"},   64'(out_idx),   64'(idx));
    check({tag, "_seq"},   64'(out_seq),   64'(seq));
    check({tag, "_total"}, 64'(out_total), 64'(total));
    check({tag, "_last"},  64'(out_last),  64'(last));
    check({tag, "_zero"},  64'(out_zero),  64'(zero));
    step();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check({tag, "_iready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_idx",    64'(out_idx),   64'd0);
    check("rst_seq",    64'(out_seq),   64'd0);
    check("rst_total",  64'(out_total), 64'd0);
    check("rst_last",   64'(out_last),  64'd0);
    check("rst_zero",   64'(out_zero),  64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_iready", 64'(in_ready), 64'd1);

    // Three sparse bits including the MSB.
    send_word(64'h8000_0000_0000_0011);
    beat("t1b0", 0,  0, 3, 1'b0, 1'b0);
    beat("t1b1", 4,  1, 3, 1'b0, 1'b0);
    beat("t1b2", 63, 2, 3, 1'b1, 1'b0);
    expect_idle("t1_end");

    // All-zero word: single flagged beat.
    send_word(64'h0);
    check("t2_iready_busy", 64'(in_ready), 64'd0);
    beat("t2b0", 0, 0, 0, 1'b1, 1'b1);
    expect_idle("t2_end");

    // All-ones word: 64 consecutive beats, total must not wrap.
    send_word({64{1'b1}});
    for (int i = 0; i < 64; i++) begin
      beat($sformatf("t3b%0d", i), i, i, 64, (i == 63), 1'b0);
    end
    expect_idle("t3_end");

    // Backpressure on the first beat of 0xA0.
    out_ready = 1'b0;
    send_word(64'h0000_0000_0000_00A0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_hold%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("t4_hold%0d_idx", i),   64'(out_idx),   64'd5);
      check($sformatf("t4_hold%0d_seq", i),   64'(out_seq),   64'd0);
      check($sformatf("t4_hold%0d_last", i),  64'(out_last),  64'd0);
      check($sformatf("t4_hold%0d_total", i), 64'(out_total), 64'd2);
      step();
    end
    out_ready = 1'b1;
    beat("t4b0", 5, 0, 2, 1'b0, 1'b0);
    beat("t4b1", 7, 1, 2, 1'b1, 1'b0);
    expect_idle("t4_end");

    // Back-to-back words with in_valid held through EMIT.
    data_in  = 64'h1;
    in_valid = 1'b1;
    step();
    data_in = 64'h6;
    check("t5_iready_emit", 64'(in_ready), 64'd0);
    beat("t5w0", 0, 0, 1, 1'b1, 1'b0);
    check("t5_gap_ovalid", 64'(out_valid), 64'd0);
    check("t5_gap_iready", 64'(in_ready),  64'd1);
    step();
    in_valid = 1'b0;
    beat("t5w1b0", 1, 0, 2, 1'b0, 1'b0);
    beat("t5w1b1", 2, 1, 2, 1'b1, 1'b0);
    expect_idle("t5_end");

    // Reset mid-word after two beats of 0xF.
    send_word(64'hF);
    beat("t6b0", 0, 0, 4, 1'b0, 1'b0);
    beat("t6b1", 1, 1, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ovalid", 64'(out_valid), 64'd0);
    check("t6_rst_seq",    64'(out_seq),   64'd0);
    check("t6_rst_last",   64'(out_last),  64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_rel_iready", 64'(in_ready),  64'd1);
    check("t6_rel_ovalid", 64'(out_valid), 64'd0);
    send_word(64'h2);
    beat("t6n0", 1, 0, 1, 1'b1, 1'b0);
    expect_idle("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bit_index_stream

// File: doc/bit_index_stream.md
BIT_INDEX_STREAM -- requirements
Module: bit_index_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of the input bitmask word.
REQ-002 SHALL have parameter IDX_WIDTH, default 6, the index width, equal to clog2(DATA_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 7, the set-bit count width, equal to clog2(DATA_WIDTH+1).
REQ-004 SHALL have port clk, input, 1 bit; the single clock, and all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit; the input word is valid.
REQ-007 SHALL have port in_ready, output, 1 bit; the block can accept a word.
REQ-008 SHALL have port data_in, input, DATA_WIDTH bits; the bitmask to enumerate.
REQ-009 SHALL have port out_valid, output, 1 bit; the index beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit; the downstream accepts the beat.
REQ-011 SHALL have port out_idx, output, IDX_WIDTH bits; the position of the current set bit.
REQ-012 SHALL have port out_seq, output, CNT_WIDTH bits; the 0-based ordinal of this beat within the word.
REQ-013 SHALL have port out_total, output, CNT_WIDTH bits; the popcount of the current word, held for all of its beats.
REQ-014 SHALL have port out_last, output, 1 bit; this is the final beat of the word.
REQ-015 SHALL have port out_zero, output, 1 bit; the word had no set bits.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and EMIT.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in EMIT.
REQ-018 SHALL, in IDLE, on in_valid&&in_ready, register data_in into the remaining-mask register and register popcount(data_in) into out_total, then move to EMIT.
REQ-019 SHALL assert out_valid exactly 1 cycle after the accepting edge, giving 1-cycle latency.
REQ-020 SHALL drive out_idx as the lowest set bit of the remaining mask, so indices emerge strictly ascending.
REQ-021 SHALL, on each out_valid&&out_ready, clear that bit in the remaining mask and increment out_seq, producing one beat per cycle under continuous out_ready.
REQ-022 SHALL assert out_last when the remaining mask has exactly one set bit.
REQ-023 SHALL return to IDLE when the out_last beat completes its handshake, and clear out_seq to 0.
REQ-024 SHALL, for an all-zero word, emit exactly one beat with out_zero=1, out_last=1, out_idx=0, out_seq=0 and out_total=0.
REQ-025 SHALL, for an all-ones word, emit DATA_WIDTH beats with out_idx 0..DATA_WIDTH-1, and out_total SHALL equal DATA_WIDTH without overflowing CNT_WIDTH.
REQ-026 SHALL hold all out_* signals stable while out_valid=1 and out_ready=0.
REQ-027 SHALL ignore in_valid in EMIT; the word is not consumed, and the upstream holds it until in_ready rises.
REQ-028 SHALL keep out_valid deasserted on the cycle after the last handshake, because in_ready rises only in IDLE; the minimum word period is popcount+1 cycles, or 2 cycles for a zero word.
REQ-029 SHALL be independent of out_ready in its in_ready logic; there is no combinational path from out_ready to in_ready.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, remaining mask=0, out_seq=0, out_total=0, out_valid=0, out_last=0 and out_zero=0, with out_idx derived as 0.
REQ-031 SHALL make in_ready=1 on the first cycle after rst_n deasserts.
REQ-032 SHALL, when reset asserts mid-word, abort the word with no further beats, and the next accepted word SHALL start at out_seq=0.

Structure
REQ-033 SHALL place DATA_WIDTH/IDX_WIDTH/CNT_WIDTH defaults and the IDLE/EMIT state encoding in the shared package gwas_bit_pkg.
REQ-034 SHALL instantiate one combinational sub-module, lsb_find, which maps a DATA_WIDTH mask to its lowest-set index plus a one-hot isolate vector; the isolate is used for bit clearing.
REQ-035 SHALL compute the load-time popcount with the existing combinational bit-count block, rather than a new adder tree.

Verification
REQ-036 SHALL cover: data_in=64'h8000_0000_0000_0011, out_ready=1 -> beats idx 0,4,63; seq 0,1,2; total=3; last on idx 63.
REQ-037 SHALL cover: data_in=0 -> one beat with out_zero=1, out_last=1, idx=0, total=0; in_ready high 2 cycles after accept.
REQ-038 SHALL cover: data_in=all-ones, out_ready=1 -> 64 consecutive beats idx 0..63, total=64, last only on beat 63.
REQ-039 SHALL cover: data_in=64'h0000_0000_0000_00A0, out_ready low 3 cycles on beat 0 -> idx=5 held stable, then idx 5,7 with no drop or duplicate.
REQ-040 SHALL cover: back-to-back in_valid with words 64'h1 then 64'h6 -> beats idx 0 (last), then 1 gap cycle, then idx 1,2; second word is not accepted during EMIT.
REQ-041 SHALL cover: rst_n pulsed low after beat 1 of 64'hF -> out_valid=0 immediately, in_ready=1 after release, next word 64'h2 yields idx 1, seq 0.
